mitm_rule_engine: RTL and testbench
===================================

Name: mitm_rule_engine

Overview:
- Parametrised successor to the single-mode MITM decision block.
- Holds a runtime-programmable table of NUM_RULES match/action rules applied to each captured MOSI/MISO word pair.
- Per eval request: selects the lowest-index matching rule, drives fake data and select lines to the line muxes, signals done.
- Sits between the SPI sniffer word-capture logic and the per-line fake/real output multiplexers.

Parameters:
- DATA_SIZE, 8: width of each SPI data word.
- NUM_RULES, 4: number of rule slots; 2..16.
- CNT_WIDTH, 8: width of the saturating hit counter.
- Derived localparam IDX_W = max(1, $clog2(NUM_RULES)).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- eval  in  1  request evaluation of the current real_* words.
- real_miso_data  in  DATA_SIZE  captured MISO word.
- real_mosi_data  in  DATA_SIZE  captured MOSI word.
- cfg_we  in  1  rule write strobe.
- cfg_addr  in  IDX_W  rule slot to write.
- cfg_enable  in  1  slot enable bit.
- cfg_match  in  DATA_SIZE  compare value, applied to MOSI word.
- cfg_mask  in  DATA_SIZE  compare mask; 1 = bit compared.
- cfg_action  in  2  0 = forward, 1 = echo MOSI on MISO, 2 = replace MISO with cfg_value, 3 = replace MOSI with cfg_value.
- cfg_value  in  DATA_SIZE  replacement word.
- fake_miso_data  out  DATA_SIZE  fake word for the MISO line.
- fake_mosi_data  out  DATA_SIZE  fake word for the MOSI line.
- fake_miso_select  out  1  1 = MISO mux outputs fake data.
- fake_mosi_select  out  1  1 = MOSI mux outputs fake data.
- done_sig  out  1  1 = idle and results valid.
- busy  out  1  1 = state other than IDLE.
- hit  out  1  last evaluation matched a rule.
- hit_idx  out  IDX_W  index of the matching rule.
- hit_count  out  CNT_WIDTH  total hits, saturating.

Behaviour:
- Reset (rst high, async):
  - All outputs 0; done_sig = 0.
  - State goes to RESET.
  - Rule table contents are not reset here; they are cleared in RESET.
- States: RESET, IDLE, MATCH, APPLY. Any other encoding goes to RESET with done_sig = 0.
- RESET (1 cycle):
  - Clear all slot enables; clear fake_* data and selects, hit, hit_idx.
  - done_sig <= 1; go to IDLE.
- IDLE:
  - If cfg_we is high, write slot cfg_addr: enable, match, mask, action, value.
  - If eval is high:
    - Capture real_mosi_data and real_miso_data into internal registers.
    - done_sig <= 0; go to MATCH.
  - A write and an eval in the same cycle: the write is visible to that evaluation.
- MATCH:
  - Per slot: hit_i = enable_i AND ((mosi_cap XOR match_i) AND mask_i) == 0.
  - Priority encoding, lowest index wins; the result is registered.
  - Go to APPLY.
- APPLY:
  - No hit: hit <= 0; hit_idx unchanged; both selects 0; fake data 0.
  - Hit: hit <= 1; hit_idx <= winning index.
  - Outputs by winning action:
    - forward: selects 0, fake data 0.
    - echo: fake_miso_select = 1, fake_miso_data = mosi_cap; fake_mosi_select = 0, fake_mosi_data = 0.
    - replace MISO: fake_miso_select = 1, fake_miso_data = value; fake_mosi_select = 0, fake_mosi_data = 0.
    - replace MOSI: fake_mosi_select = 1, fake_mosi_data = value; fake_miso_select = 0, fake_miso_data = 0.
  - done_sig <= 1; go to IDLE.
- Latency: eval sampled at edge N; results and done_sig = 1 visible after edge N+2.
- Outputs hold their values until the next APPLY or reset.
- cfg_we while busy is ignored and the write is dropped. busy = (state != IDLE).
- eval while busy is ignored; no queuing.
- A mask of all zeros matches every MOSI word. A disabled slot never matches.
- Mid-operation reset aborts the evaluation; no partial outputs; the table is cleared.

Optional Feature:
- MITM_HIT_COUNT_EN
- Defined:
  - hit_count increments by 1 in every APPLY with a hit.
  - Saturates at 2^CNT_WIDTH - 1.
  - Cleared by reset or by the RESET state.
- Undefined: hit_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset then eval with MOSI = 0xA5, empty table -> done_sig falls, rises 2 cycles later; hit = 0; both selects 0; fake data 0.
- Slot 0 = {en, match 0x90, mask 0xF0, action 2, value 0x3C}; eval MOSI = 0x9F -> hit = 1, hit_idx = 0, fake_miso_select = 1, fake_miso_data = 0x3C; MOSI = 0x8F -> hit = 0.
- Slot 1 action 1 mask 0x00, slot 3 action 3 mask 0x00 -> eval MOSI = 0x42: hit_idx = 1, fake_miso_data = 0x42, fake_mosi_select = 0 (priority check).
- cfg_we to slot 2 asserted one cycle after eval (busy = 1) -> slot 2 unchanged on readback via a later matching eval; cfg_we with eval in the same IDLE cycle -> new rule used.
- rst pulsed during MATCH -> all outputs 0 immediately; after RESET, done_sig = 1 and a previously matching eval gives hit = 0.
- MITM_HIT_COUNT_EN with CNT_WIDTH = 2, 5 matching evals -> hit_count 1, 2, 3, 3, 3; without the macro, hit_count stays 0.

Source files
------------

// File: rtl/mitm_rule_engine_if.sv
// Sniffer/mux-facing bus of the MITM rule engine: captured word pair, rule programming port
// and the fake-data/select results driven toward the per-line output multiplexers.
interface mitm_rule_engine_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_RULES = 4,
    parameter int CNT_WIDTH = 8
);
    localparam int IDX_W = ($clog2(NUM_RULES) > 1) ? $clog2(NUM_RULES) : 1;

    logic                 eval;
    logic [DATA_SIZE-1:0] real_miso_data;
    logic [DATA_SIZE-1:0] real_mosi_data;

    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_addr;
    logic                 cfg_enable;
    logic [DATA_SIZE-1:0] cfg_match;
    logic [DATA_SIZE-1:0] cfg_mask;
    logic [1:0]           cfg_action;
    logic [DATA_SIZE-1:0] cfg_value;

    logic [DATA_SIZE-1:0] fake_miso_data;
    logic [DATA_SIZE-1:0] fake_mosi_data;
    logic                 fake_miso_select;
    logic                 fake_mosi_select;
    logic                 done_sig;
    logic                 busy;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [CNT_WIDTH-1:0] hit_count;

    modport master (
        output eval, real_miso_data, real_mosi_data,
        output cfg_we, cfg_addr, cfg_enable, cfg_match, cfg_mask, cfg_action, cfg_value,
        input  fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select,
        input  done_sig, busy, hit, hit_idx, hit_count
    );

    modport slave (
        input  eval, real_miso_data, real_mosi_data,
        input  cfg_we, cfg_addr, cfg_enable, cfg_match, cfg_mask, cfg_action, cfg_value,
        output fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select,
        output done_sig, busy, hit, hit_idx, hit_count
    );
endinterface

// File: rtl/mitm_rule_engine.sv
// Programmable MITM rule engine: lowest-index matching rule picks the fake data/selects per eval.
// Optional saturating hit counter built only when MITM_HIT_COUNT_EN is defined.
module mitm_rule_engine #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_RULES = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic            sys_clk,
    input  logic            rst,
    mitm_rule_engine_if.slave bus
);
    localparam int IDX_W = ($clog2(NUM_RULES) > 1) ? $clog2(NUM_RULES) : 1;
    localparam logic [IDX_W:0] NUM_RULES_W = (IDX_W + 1)'(NUM_RULES);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MATCH = 2'd2,
        ST_APPLY = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                 rule_en     [NUM_RULES];
    logic [DATA_SIZE-1:0] rule_match  [NUM_RULES];
    logic [DATA_SIZE-1:0] rule_mask   [NUM_RULES];
    logic [1:0]           rule_action [NUM_RULES];
    logic [DATA_SIZE-1:0] rule_value  [NUM_RULES];

    logic [DATA_SIZE-1:0] mosi_cap_p0;
    logic [DATA_SIZE-1:0] miso_cap_p0;
    logic                 match_hit;
    logic [IDX_W-1:0]     match_idx;
    logic                 win_hit_p1;
    logic [IDX_W-1:0]     win_idx_p1;
    logic                 cfg_wr;

    logic [DATA_SIZE-1:0] fake_miso_data_q, fake_miso_data_nxt;
    logic [DATA_SIZE-1:0] fake_mosi_data_q, fake_mosi_data_nxt;
    logic                 fake_miso_sel_q,  fake_miso_sel_nxt;
    logic                 fake_mosi_sel_q,  fake_mosi_sel_nxt;
    logic                 done_q,           done_nxt;
    logic                 hit_q,            hit_nxt;
    logic [IDX_W-1:0]     hit_idx_q,        hit_idx_nxt;

    // Programming is only accepted while idle; writes during an evaluation are dropped.
    assign cfg_wr = (state == ST_IDLE) && bus.cfg_we && ({1'b0, bus.cfg_addr} < NUM_RULES_W);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_RESET;
        case (state)
            ST_RESET: state_nxt = ST_IDLE;
            ST_IDLE:  state_nxt = bus.eval ? ST_MATCH : ST_IDLE;
            ST_MATCH: state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_RESET;
        endcase
    end

    // Table storage carries no reset; the RESET state clears the enables instead.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NUM_RULES; i++) begin
            if (state == ST_RESET) begin
                rule_en[i] <= 1'b0;
            end else if (cfg_wr && (bus.cfg_addr == IDX_W'(i))) begin
                rule_en[i]     <= bus.cfg_enable;
                rule_match[i]  <= bus.cfg_match;
                rule_mask[i]   <= bus.cfg_mask;
                rule_action[i] <= bus.cfg_action;
                rule_value[i]  <= bus.cfg_value;
            end
        end
    end

    // p0: captured word pair
    always_ff @(posedge sys_clk) begin
        if ((state == ST_IDLE) && bus.eval) begin
            mosi_cap_p0 <= bus.real_mosi_data;
            miso_cap_p0 <= bus.real_miso_data;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (rule_en[i] && (((mosi_cap_p0 ^ rule_match[i]) & rule_mask[i]) == '0)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // p1: registered priority-encoder result
    always_ff @(posedge sys_clk) begin
        if (state == ST_MATCH) begin
            win_hit_p1 <= match_hit;
            win_idx_p1 <= match_idx;
        end
    end

    always_comb begin
        fake_miso_data_nxt = fake_miso_data_q;
        fake_mosi_data_nxt = fake_mosi_data_q;
        fake_miso_sel_nxt  = fake_miso_sel_q;
        fake_mosi_sel_nxt  = fake_mosi_sel_q;
        done_nxt           = done_q;
        hit_nxt            = hit_q;
        hit_idx_nxt        = hit_idx_q;
        case (state)
            ST_RESET: begin
                fake_miso_data_nxt = '0;
                fake_mosi_data_nxt = '0;
                fake_miso_sel_nxt  = 1'b0;
                fake_mosi_sel_nxt  = 1'b0;
                hit_nxt            = 1'b0;
                hit_idx_nxt        = '0;
                done_nxt           = 1'b1;
            end
            ST_IDLE: begin
                if (bus.eval) begin
                    done_nxt = 1'b0;
                end
            end
            ST_MATCH: begin
            end
            ST_APPLY: begin
                fake_miso_data_nxt = '0;
                fake_mosi_data_nxt = '0;
                fake_miso_sel_nxt  = 1'b0;
                fake_mosi_sel_nxt  = 1'b0;
                hit_nxt            = win_hit_p1;
                done_nxt           = 1'b1;
                if (win_hit_p1) begin
                    hit_idx_nxt = win_idx_p1;
                    case (rule_action[win_idx_p1])
                        2'd1: begin
                            fake_miso_sel_nxt  = 1'b1;
                            fake_miso_data_nxt = mosi_cap_p0;
                        end
                        2'd2: begin
                            fake_miso_sel_nxt  = 1'b1;
                            fake_miso_data_nxt = rule_value[win_idx_p1];
                        end
                        2'd3: begin
                            fake_mosi_sel_nxt  = 1'b1;
                            fake_mosi_data_nxt = rule_value[win_idx_p1];
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: done_nxt = 1'b0;
        endcase
    end

    // p2: result registers presented to the line muxes
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            fake_miso_data_q <= '0;
            fake_mosi_data_q <= '0;
            fake_miso_sel_q  <= 1'b0;
            fake_mosi_sel_q  <= 1'b0;
            done_q           <= 1'b0;
            hit_q            <= 1'b0;
            hit_idx_q        <= '0;
        end else begin
            fake_miso_data_q <= fake_miso_data_nxt;
            fake_mosi_data_q <= fake_mosi_data_nxt;
            fake_miso_sel_q  <= fake_miso_sel_nxt;
            fake_mosi_sel_q  <= fake_mosi_sel_nxt;
            done_q           <= done_nxt;
            hit_q            <= hit_nxt;
            hit_idx_q        <= hit_idx_nxt;
        end
    end

`ifdef MITM_HIT_COUNT_EN
    logic [CNT_WIDTH-1:0] hit_count_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hit_count_q <= '0;
        end else if (state == ST_RESET) begin
            hit_count_q <= '0;
        end else if ((state == ST_APPLY) && win_hit_p1 && (hit_count_q != '1)) begin
            hit_count_q <= hit_count_q + 1'b1;
        end
    end

    assign bus.hit_count = hit_count_q;
`else
    assign bus.hit_count = '0;
`endif

    assign bus.fake_miso_data   = fake_miso_data_q;
    assign bus.fake_mosi_data   = fake_mosi_data_q;
    assign bus.fake_miso_select = fake_miso_sel_q;
    assign bus.fake_mosi_select = fake_mosi_sel_q;
    assign bus.done_sig         = done_q;
    assign bus.hit              = hit_q;
    assign bus.hit_idx          = hit_idx_q;
    assign bus.busy             = (state != ST_IDLE);
endmodule

// File: tb/tb_mitm_rule_engine.sv
// Bench for mitm_rule_engine: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a rule-list reference model.
module tb_mitm_rule_engine;
    localparam int DATA_SIZE = 8;
    localparam int NUM_RULES = 4;
    localparam int CNT_WIDTH = 2;
    localparam int IDX_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    mitm_rule_engine_if #(.DATA_SIZE(DATA_SIZE), .NUM_RULES(NUM_RULES), .CNT_WIDTH(CNT_WIDTH)) bus ();

    mitm_rule_engine #(.DATA_SIZE(DATA_SIZE), .NUM_RULES(NUM_RULES), .CNT_WIDTH(CNT_WIDTH)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit en;
        int addr;
        int match;
        int mask;
        int action;
        int value;
    } rule_t;

    typedef struct {
        int mosi;
        int miso;
        int hit;
        int idx;
        int miso_sel;
        int miso_d;
        int mosi_sel;
        int mosi_d;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    bit m_en     [NUM_RULES];
    int m_match  [NUM_RULES];
    int m_mask   [NUM_RULES];
    int m_action [NUM_RULES];
    int m_value  [NUM_RULES];
    int m_hit, m_idx, m_miso_sel, m_miso_d, m_mosi_sel, m_mosi_d, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef MITM_HIT_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_RULES; i++) m_en[i] = 1'b0;
        m_hit = 0; m_idx = 0; m_miso_sel = 0; m_miso_d = 0; m_mosi_sel = 0; m_mosi_d = 0; m_cnt = 0;
    endtask

    task automatic model_write(input rule_t r);
        m_en[r.addr]     = r.en;
        m_match[r.addr]  = r.match & 8'hFF;
        m_mask[r.addr]   = r.mask & 8'hFF;
        m_action[r.addr] = r.action & 3;
        m_value[r.addr]  = r.value & 8'hFF;
    endtask

    // First enabled rule whose masked bits equal the MOSI word decides the outcome.
    task automatic model_eval(input int mosi);
        int w;
        w = -1;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (w < 0 && m_en[i] && (((mosi ^ m_match[i]) & m_mask[i] & 8'hFF) == 0)) w = i;
        end
        m_miso_sel = 0; m_miso_d = 0; m_mosi_sel = 0; m_mosi_d = 0;
        if (w < 0) begin
            m_hit = 0;
        end else begin
            m_hit = 1;
            m_idx = w;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_action[w] == 1) begin m_miso_sel = 1; m_miso_d = mosi & 8'hFF; end
            if (m_action[w] == 2) begin m_miso_sel = 1; m_miso_d = m_value[w]; end
            if (m_action[w] == 3) begin m_mosi_sel = 1; m_mosi_d = m_value[w]; end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".hit"},       32'(bus.hit), m_hit);
        check({tag, ".hit_idx"},   32'(bus.hit_idx), m_idx);
        check({tag, ".miso_sel"},  32'(bus.fake_miso_select), m_miso_sel);
        check({tag, ".miso_data"}, 32'(bus.fake_miso_data), m_miso_d);
        check({tag, ".mosi_sel"},  32'(bus.fake_mosi_select), m_mosi_sel);
        check({tag, ".mosi_data"}, 32'(bus.fake_mosi_data), m_mosi_d);
        check({tag, ".hit_count"}, 32'(bus.hit_count), exp_count());
    endtask

    task automatic drive_rule(input rule_t r);
        bus.cfg_enable = r.en;
        bus.cfg_addr   = IDX_W'(r.addr);
        bus.cfg_match  = 8'(r.match);
        bus.cfg_mask   = 8'(r.mask);
        bus.cfg_action = 2'(r.action);
        bus.cfg_value  = 8'(r.value);
    endtask

    task automatic program_rule(input rule_t r);
        drive_rule(r);
        bus.cfg_we = 1'b1;
        @(posedge sys_clk); #1;
        bus.cfg_we = 1'b0;
        model_write(r);
    endtask

    // mode 0: plain eval; 1: cfg write in the eval cycle; 2: cfg write and a second eval while busy
    task automatic do_eval(input int mosi, input int miso, input int mode, input rule_t r);
        bus.real_mosi_data = 8'(mosi);
        bus.real_miso_data = 8'(miso);
        bus.eval = 1'b1;
        if (mode == 1) begin
            drive_rule(r);
            bus.cfg_we = 1'b1;
            model_write(r);
        end
        @(posedge sys_clk); #1;
        bus.eval = 1'b0;
        bus.cfg_we = 1'b0;
        check("done_low_match", 32'(bus.done_sig), 0);
        check("busy_match", 32'(bus.busy), 1);
        if (mode == 2) begin
            drive_rule(r);
            bus.cfg_we = 1'b1;
            bus.eval = 1'b1;
            bus.real_mosi_data = 8'(mosi ^ 8'hFF);
        end
        @(posedge sys_clk); #1;
        bus.cfg_we = 1'b0;
        bus.eval = 1'b0;
        check("done_low_apply", 32'(bus.done_sig), 0);
        @(posedge sys_clk); #1;
        model_eval(mosi);
        check("done_high", 32'(bus.done_sig), 1);
        check("busy_idle", 32'(bus.busy), 0);
        check_outputs("eval");
    endtask

    vec_t  vecs [4];
    rule_t r_none;
    rule_t r;
    int    cnt_exp [5];

    initial begin
        r_none = '{en: 1'b0, addr: 0, match: 0, mask: 0, action: 0, value: 0};
        vecs[0] = '{mosi: 8'h9F, miso: 8'h11, hit: 1, idx: 0, miso_sel: 1, miso_d: 8'h3C, mosi_sel: 0, mosi_d: 0};
        vecs[1] = '{mosi: 8'h8F, miso: 8'h22, hit: 0, idx: 0, miso_sel: 0, miso_d: 0,     mosi_sel: 0, mosi_d: 0};
        vecs[2] = '{mosi: 8'h42, miso: 8'h33, hit: 1, idx: 1, miso_sel: 1, miso_d: 8'h42, mosi_sel: 0, mosi_d: 0};
        vecs[3] = '{mosi: 8'h9A, miso: 8'h44, hit: 1, idx: 0, miso_sel: 1, miso_d: 8'h3C, mosi_sel: 0, mosi_d: 0};
`ifdef MITM_HIT_COUNT_EN
        cnt_exp = '{1, 2, 3, 3, 3};
`else
        cnt_exp = '{0, 0, 0, 0, 0};
`endif

        bus.eval = 1'b0; bus.real_mosi_data = '0; bus.real_miso_data = '0;
        bus.cfg_we = 1'b0; drive_rule(r_none);
        model_reset();

        // Reset state
        #2;
        check("reset.done", 32'(bus.done_sig), 0);
        check_outputs("reset");
        @(posedge sys_clk); @(posedge sys_clk); #1;
        rst = 1'b0;
        @(posedge sys_clk); #1;
        check("after_reset.done", 32'(bus.done_sig), 1);
        check("after_reset.busy", 32'(bus.busy), 0);

        // Empty table
        do_eval(8'hA5, 8'h5A, 0, r_none);

        // Directed vector table
        program_rule('{en: 1'b1, addr: 0, match: 8'h90, mask: 8'hF0, action: 2, value: 8'h3C});
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                program_rule('{en: 1'b1, addr: 1, match: 8'h00, mask: 8'h00, action: 1, value: 8'h00});
                program_rule('{en: 1'b1, addr: 3, match: 8'h00, mask: 8'h00, action: 3, value: 8'h77});
            end
            do_eval(vecs[i].mosi, vecs[i].miso, 0, r_none);
            check("vec.hit",       32'(bus.hit), vecs[i].hit);
            check("vec.hit_idx",   32'(bus.hit_idx), vecs[i].idx);
            check("vec.miso_sel",  32'(bus.fake_miso_select), vecs[i].miso_sel);
            check("vec.miso_data", 32'(bus.fake_miso_data), vecs[i].miso_d);
            check("vec.mosi_sel",  32'(bus.fake_mosi_select), vecs[i].mosi_sel);
            check("vec.mosi_data", 32'(bus.fake_mosi_data), vecs[i].mosi_d);
        end

        // Write while busy is dropped; write with eval in the same cycle is used
        program_rule('{en: 1'b0, addr: 1, match: 0, mask: 0, action: 1, value: 0});
        r = '{en: 1'b1, addr: 2, match: 8'h55, mask: 8'hFF, action: 3, value: 8'hEE};
        do_eval(8'h55, 8'h00, 2, r);
        do_eval(8'h55, 8'h00, 0, r_none);
        check("busy_write.hit_idx", 32'(bus.hit_idx), 3);
        check("busy_write.mosi_data", 32'(bus.fake_mosi_data), 8'h77);
        do_eval(8'h55, 8'h00, 1, r);
        check("same_cycle.hit_idx", 32'(bus.hit_idx), 2);
        check("same_cycle.mosi_data", 32'(bus.fake_mosi_data), 8'hEE);

        // Reset during MATCH
        bus.real_mosi_data = 8'h55;
        bus.eval = 1'b1;
        @(posedge sys_clk); #1;
        bus.eval = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_reset.done", 32'(bus.done_sig), 0);
        check_outputs("mid_reset");
        @(posedge sys_clk); #1;
        rst = 1'b0;
        @(posedge sys_clk); #1;
        check("post_reset.done", 32'(bus.done_sig), 1);
        do_eval(8'h55, 8'h00, 0, r_none);
        check("post_reset.hit", 32'(bus.hit), 0);

        // Saturating hit counter
        program_rule('{en: 1'b1, addr: 0, match: 8'h00, mask: 8'h00, action: 0, value: 8'h00});
        for (int i = 0; i < 5; i++) begin
            do_eval($urandom_range(0, 255), 0, 0, r_none);
            check("count_seq", 32'(bus.hit_count), cnt_exp[i]);
        end

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            int    sel, mosi;
            rule_t rr;
            sel = $urandom_range(0, 4);
            rr.addr   = $urandom_range(0, NUM_RULES - 1);
            rr.en     = ($urandom_range(0, 3) != 0);
            rr.match  = $urandom_range(0, 255);
            rr.action = $urandom_range(0, 3);
            rr.value  = $urandom_range(0, 255);
            case (sel)
                0: rr.mask = 0;
                1: rr.mask = 8'hFF;
                2: rr.mask = 8'hF0;
                3: rr.mask = 8'h0F;
                default: rr.mask = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                program_rule(rr);
            end else begin
                mosi = ($urandom_range(0, 1) == 0) ? m_match[$urandom_range(0, NUM_RULES - 1)]
                                                   : int'($urandom_range(0, 255));
                do_eval(mosi, $urandom_range(0, 255), $urandom_range(0, 2), rr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
